// File: rtl/risc_prog_loader.sv
// VeriRISC program loader: streams bytes into CPU memory, boots and supervises the run.
// Optional LOAD_CHECKSUM_EN adds a running modulo sum of loaded bytes.
module risc_prog_loader #(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 8,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [15:0]       cycle_count
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BOOT, S_RUN, S_DONE, S_ERR
  } state_t;

  localparam logic [AWIDTH-1:0] PTR_MAX   = '1;
  localparam logic [15:0]       LIMIT_M1  = 16'(MAX_CYCLES - 1);
  localparam logic [3:0]        BOOT_LAST = 4'(RST_CYCLES - 1);

  state_t            state, state_nx;
  logic [1:0]        err_nx;
  logic [AWIDTH-1:0] ptr;
  logic [3:0]        boot_cnt;
  logic              accept;

  // Ready decodes only the state register, never in_valid.
  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      err   <= 2'd0;
    end else begin
      state <= state_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    err_nx   = err;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid)
          state_nx = in_last ? S_BOOT : S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (in_valid) begin
          if (in_last) begin
            state_nx = S_BOOT;
          end else if (ptr == PTR_MAX) begin
            state_nx = S_ERR;
            err_nx   = 2'd1;
          end
        end
      end
      S_BOOT: begin
        busy = 1'b1;
        if (boot_cnt == BOOT_LAST)
          state_nx = S_RUN;
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
        // Halt beats the cycle limit when both land together.
        if (cpu_halt) begin
          state_nx = S_DONE;
        end else if (cycle_count == LIMIT_M1) begin
          state_nx = S_ERR;
          err_nx   = 2'd2;
        end
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      S_ERR: begin
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      boot_cnt    <= 4'd0;
      cycle_count <= 16'd0;
    end else begin
      mem_wr <= accept;
      if (accept) begin
        mem_addr  <= ptr;
        mem_wdata <= in_data;
        if (ptr != PTR_MAX)
          ptr <= ptr + 1'b1;
      end
      boot_cnt <= (state == S_BOOT) ? boot_cnt + 4'd1 : 4'd0;
      if (state == S_BOOT)
        cycle_count <= 16'd0;
      else if (state == S_RUN && !cpu_halt && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      checksum <= '0;
    else if (accept)
      checksum <= checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader: load, boot, halt, overflow, timeout, abort.
// Honours LOAD_CHECKSUM_EN when defined.
module tb_risc_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        mem_wr;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        cpu_halt = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [15:0] cycle_count;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  risc_prog_loader #(
    .AWIDTH(5), .DWIDTH(8), .RST_CYCLES(2), .MAX_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .cpu_halt(cpu_halt),
    .busy(busy), .done(done), .err(err),
    .cycle_count(cycle_count)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cpu_halt = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_count", cycle_count, 0);

    // single HLT byte, halt stub 3 cycles after release
    send(8'h00, 1'b1);
    chk("hlt_wr", mem_wr, 1);
    chk("hlt_addr", mem_addr, 0);
    chk("hlt_data", mem_wdata, 8'h00);
    chk("hlt_boot_busy", busy, 1);
    chk("hlt_boot_ready", in_ready, 0);
    chk("hlt_boot_cpurst1", cpu_rst, 1);
    step();
    chk("hlt_wr_off", mem_wr, 0);
    chk("hlt_boot_cpurst2", cpu_rst, 1);
    step();
    chk("hlt_release", cpu_rst, 0);
    chk("hlt_run_busy", busy, 1);
    repeat (3) step();
    chk("hlt_run_cnt", cycle_count, 3);
    cpu_halt = 1'b1;
    step();
    chk("hlt_done", done, 1);
    chk("hlt_count", cycle_count, 3);
    chk("hlt_done_busy", busy, 0);
    chk("hlt_done_cpurst", cpu_rst, 0);
    chk("hlt_done_ready", in_ready, 0);
    cpu_halt = 1'b0;
    step();
    chk("hlt_done_hold", done, 1);
    chk("hlt_count_hold", cycle_count, 3);

    // JMP program with gapped valid
    do_reset();
    begin
      logic [7:0] prog [3];
      prog = '{8'hE2, 8'h00, 8'h00};
      for (int i = 0; i < 3; i++) begin
        send(prog[i], i == 2);
        chk("jmp_wr", mem_wr, 1);
        chk("jmp_addr", mem_addr, i);
        chk("jmp_data", mem_wdata, prog[i]);
        if (i < 2) begin
          chk("jmp_load_ready", in_ready, 1);
          step();
          chk("jmp_gap_wr", mem_wr, 0);
        end
      end
    end
    chk("jmp_boot_ready", in_ready, 0);
    chk("jmp_boot_cpurst", cpu_rst, 1);
    chk("jmp_boot_busy", busy, 1);
    step();
    chk("jmp_tail_wr", mem_wr, 0);

    // 32 bytes without last -> overflow
    do_reset();
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      in_data = 8'(i + 8'h10);
      step();
      chk("ovf_wr", mem_wr, 1);
      chk("ovf_addr", mem_addr, i);
      chk("ovf_data", mem_wdata, i + 8'h10);
    end
    chk("ovf_err_now", err, 1);
    in_data = 8'hAA;
    step();
    chk("ovf_33_wr", mem_wr, 0);
    chk("ovf_err", err, 1);
    chk("ovf_cpurst", cpu_rst, 1);
    chk("ovf_ready", in_ready, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_done", done, 0);
    in_valid = 1'b0;

    // run timeout with MAX_CYCLES=16
    do_reset();
    send(8'h00, 1'b1);
    step();
    step();
    chk("to_release", cpu_rst, 0);
    repeat (15) step();
    chk("to_cnt15", cycle_count, 15);
    chk("to_err_pre", err, 0);
    step();
    chk("to_err", err, 2);
    chk("to_cnt", cycle_count, 16);
    chk("to_cpurst", cpu_rst, 1);
    chk("to_busy", busy, 0);
    cpu_halt = 1'b1;
    step();
    chk("to_err_hold", err, 2);
    chk("to_done_hold", done, 0);
    cpu_halt = 1'b0;

    // abort mid-load, then reload from address 0
    do_reset();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    chk("ab_addr3", mem_addr, 3);
    do_reset();
    chk("ab_ready", in_ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_wr", mem_wr, 0);
    send(8'hFF, 1'b0);
    chk("ab_addr0", mem_addr, 0);
    chk("ab_data0", mem_wdata, 8'hFF);
    send(8'h01, 1'b0);
    chk("ab_addr1", mem_addr, 1);
    send(8'hFE, 1'b1);
    chk("ab_addr2", mem_addr, 2);
    chk("ab_boot_ready", in_ready, 0);
`ifdef LOAD_CHECKSUM_EN
    chk("ab_checksum", checksum, 8'hFE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/risc_prog_loader.md
Name: risc_prog_loader

Overview:
- Hardware program loader and run supervisor for the VeriRISC CPU.
- Accepts a byte stream over a valid/ready handshake and writes it into the CPU memory from address 0 upward.
- Holds the CPU in reset while loading, then releases it and runs the program.
- Counts run cycles until the CPU asserts halt, and reports done or error; a bench or host needs no hierarchical memory pokes.

Parameters:
AWIDTH, 5, memory address width (matches 5-bit instruction operand)
DWIDTH, 8, memory word / stream byte width
RST_CYCLES, 2, cycles cpu_rst is held asserted after load completes (1..15)
MAX_CYCLES, 1024, run-cycle limit before timeout error (2..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  stream byte valid
in_ready  out  1  loader can accept a byte
in_data  in  DWIDTH  stream byte (instruction or data word)
in_last  in  1  marks final byte of program
mem_wr  out  1  memory write strobe
mem_addr  out  AWIDTH  memory write address
mem_wdata  out  DWIDTH  memory write data
cpu_rst  out  1  reset to CPU (active-high)
cpu_halt  in  1  CPU halt flag
busy  out  1  high in LOAD/BOOT/RUN
done  out  1  program halted normally
err  out  2  0 none, 1 overflow, 2 timeout
cycle_count  out  16  RUN cycles elapsed until halt

Behaviour:
- Reset (rst=1, sampled on posedge clk): state=IDLE, ptr=0, mem_wr=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, cycle_count=0. A reset mid-operation aborts at once; partial memory contents are left as written.
- Handshake: a byte is accepted on a posedge where in_valid&&in_ready. in_ready=1 only in IDLE and LOAD, and is a registered function of state, never of in_valid.
- Write path, 1-cycle latency: on acceptance at ptr, the next cycle has mem_wr=1, mem_addr=ptr, mem_wdata=in_data. mem_wr=0 otherwise. Back-to-back acceptance gives back-to-back writes.
- IDLE: cpu_rst=1. First accepted byte is written to address 0 and moves to LOAD; if in_last=1 it moves to BOOT instead.
- LOAD: cpu_rst=1, busy=1. Each accept writes to ptr and increments ptr.
  - in_last=1 on accept -> BOOT.
  - Accept at ptr=2^AWIDTH-1 with in_last=0 -> byte still written, then ERR with err=1. No wrap-around to 0.
- BOOT: cpu_rst=1, busy=1. Lasts RST_CYCLES cycles, counted from the cycle after the last accept, so the final write completes inside BOOT. Then RUN; cycle_count cleared to 0 on entry.
- RUN: cpu_rst=0, busy=1.
  - cycle_count increments every cycle cpu_halt=0.
  - First cycle cpu_halt=1 -> DONE; cycle_count frozen (that cycle not counted).
  - cycle_count reaching MAX_CYCLES with cpu_halt=0 -> ERR with err=2.
  - Halt and limit in the same cycle: halt wins (DONE).
- DONE: done=1, busy=0, cpu_rst=0 (CPU stays halted), in_ready=0. Exits only via rst.
- ERR: err held, done=0, busy=0, cpu_rst=1, in_ready=0. Exits only via rst.
- cpu_halt is ignored outside RUN. in_valid in BOOT/RUN/DONE/ERR is not accepted (in_ready=0); the byte is not consumed.
- cycle_count saturates at 16'hFFFF. Arithmetic is unsigned.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- Defined: adds output checksum [DWIDTH-1:0]. It is the modulo-2^DWIDTH sum of all accepted bytes, cleared by rst, updated on each accept, and valid from BOOT onward.
- Undefined: no checksum port and no adder logic; all other behaviour is identical.

Test Plan:
- Reset: rst 1 cycle -> cpu_rst=1, in_ready=1, busy=0, done=0, err=0, mem_wr=0.
- Single byte 8'h00 with in_last=1 (HLT) -> next cycle mem_wr=1, addr=0, data=00. cpu_rst stays high 2 cycles, then drops. A halt stub asserting 3 cycles after release gives done=1, cycle_count=3.
- JMP program bytes E2, 00, 00 (last on third) with in_valid gapped every other cycle -> exactly 3 writes to addr 0,1,2 in order, no write in gap cycles, BOOT entered after third accept.
- 32 bytes with in_last never asserted -> 32 writes (addr 0..31), then err=1, cpu_rst=1, in_ready=0. A 33rd in_valid is not accepted.
- Load then halt stub held low, MAX_CYCLES=16 -> err=2 after 16 RUN cycles, cycle_count=16, cpu_rst reasserted.
- rst pulsed mid-LOAD after 4 bytes -> IDLE, ptr=0, next byte written to addr 0. With LOAD_CHECKSUM_EN, bytes FF, 01, FE -> checksum=8'hFE.
